// File: rtl/adc_rd_pkg.sv
// Shared constants and state encoding for the ADC FIFO block reader.
package adc_rd_pkg;

  localparam int DOUT_W    = 32;
  localparam int BEATS     = 8;
  localparam int BLK_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BLOCK = 2'd2
  } rd_state_e;

endpackage

// File: rtl/adc_fifo_block_reader_skid.sv
// Two-entry word skid: head is the word being sliced, tail is the prefetched next word.
module fifo_word_skid2 #(
  parameter int W = 256
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_head_valid,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_count;
  logic         w_pop;

  assign w_pop = i_pop && (r_count != 2'd0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (i_push) begin
            r_head  <= i_push_data;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (w_pop && i_push) begin
            r_head <= i_push_data;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end else if (i_push) begin
            r_tail  <= i_push_data;
            r_count <= 2'd2;
          end
        end
        default: begin
          // Pop shifts tail into head; a same-cycle push refills the freed tail.
          if (w_pop) begin
            r_head <= r_tail;
            if (i_push) r_tail <= i_push_data;
            else        r_count <= 2'd1;
          end
        end
      endcase
    end
  end

  assign o_head       = r_head;
  assign o_head_valid = (r_count != 2'd0);
  assign o_count      = r_count;

  a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && !i_pop && (r_count == 2'd2)));

endmodule

// File: rtl/adc_fifo_block_reader.sv
// Prefetches FIFO words into a 2-word skid and streams them as 32-bit beats,
// advertising a block only once every word of it is already reachable.
//
// state  | meaning
// IDLE   | waiting for a full block of words (FIFO + held)
// ARMED  | block available, o_pipe_ready high, waiting for first read
// BLOCK  | streaming beats until the block's last beat is read
module adc_fifo_block_reader
  import adc_rd_pkg::*;
#(
  parameter int DIN_W       = 256,
  parameter int CNT_W       = 7,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic                 o_fifo_rd_en,
  input  logic                 i_fifo_empty,
  input  logic                 i_fifo_valid,
  input  logic [DIN_W-1:0]     i_fifo_data,
  input  logic [CNT_W-1:0]     i_fifo_rd_data_cnt,
  output logic                 o_pipe_ready,
  input  logic                 i_pipe_rd,
  output logic [DOUT_W-1:0]    o_pipe_data,
  output logic                 o_underrun,
  output logic [BLK_CNT_W-1:0] o_blocks_done
);

  localparam int K_W         = $clog2(BEATS);
  localparam int TOTAL_BEATS = BLOCK_WORDS * BEATS;
  localparam int BC_W        = $clog2(TOTAL_BEATS);
  localparam int OCC_W       = CNT_W + 2;

  rd_state_e              r_state;
  logic                   r_pipe_ready;
  logic                   r_underrun;
  logic [BLK_CNT_W-1:0]   r_blocks_done;
  logic [K_W-1:0]         r_k;
  logic [BC_W-1:0]        r_beat_cnt;
  logic                   r_inflight;

  logic [DIN_W-1:0]       w_head;
  logic                   w_head_valid;
  logic [1:0]             w_count;
  logic [OCC_W-1:0]       w_occ;
  logic                   w_arm;
  logic                   w_rd_en;
  logic                   w_take;
  logic                   w_last_k;
  logic                   w_pop;
  logic                   w_last_beat;

  fifo_word_skid2 #(.W(DIN_W)) u_skid (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (i_fifo_valid),
    .i_push_data  (i_fifo_data),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_head_valid (w_head_valid),
    .o_count      (w_count)
  );

  // In-flight read is counted as held so the FIFO count lagging can only under-report.
  assign w_occ = OCC_W'(i_fifo_rd_data_cnt) + OCC_W'(w_count) + OCC_W'(r_inflight);
  assign w_arm = (w_occ >= OCC_W'(BLOCK_WORDS));

  assign w_rd_en = !i_rst && !i_fifo_empty && !r_inflight && (w_count < 2'd2);

  assign w_take      = i_pipe_rd && w_head_valid && (r_state != ST_IDLE);
  assign w_last_k    = (r_k == K_W'(BEATS - 1));
  assign w_pop       = w_take && w_last_k;
  assign w_last_beat = (r_beat_cnt == BC_W'(TOTAL_BEATS - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inflight <= 1'b0;
    end else if (w_rd_en) begin
      r_inflight <= 1'b1;
    end else if (i_fifo_valid) begin
      r_inflight <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_pipe_ready  <= 1'b0;
      r_underrun    <= 1'b0;
      r_blocks_done <= '0;
      r_k           <= '0;
      r_beat_cnt    <= '0;
    end else begin
      if (i_pipe_rd && !w_take) r_underrun <= 1'b1;
      if (w_take) r_k <= w_last_k ? '0 : r_k + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_arm) begin
            r_state      <= ST_ARMED;
            r_pipe_ready <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (w_take) begin
            r_state      <= ST_BLOCK;
            r_pipe_ready <= 1'b0;
            r_beat_cnt   <= BC_W'(1);
          end
        end
        ST_BLOCK: begin
          if (w_take) begin
            if (w_last_beat) begin
              r_state       <= ST_IDLE;
              r_beat_cnt    <= '0;
              r_blocks_done <= r_blocks_done + 1'b1;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_pipe_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_fifo_rd_en  = w_rd_en;
  assign o_pipe_ready  = r_pipe_ready;
  assign o_pipe_data   = w_head[r_k*DOUT_W +: DOUT_W];
  assign o_underrun    = r_underrun;
  assign o_blocks_done = r_blocks_done;

endmodule

// File: doc/adc_fifo_block_reader.md
Name: adc_fifo_block_reader

Overview:
- Downstream consumer of the 256-bit ADC sample FIFO read port (p0 side); runs entirely in the FIFO read-clock domain.
- Prefetches 256-bit FIFO words, slices them into 32-bit beats and presents them to a host block-throttled pipe-out.
- Raises a block-ready flag only when a full block is available, so the host never stalls mid-block.
- Reports underrun and block statistics for the host status registers.

Parameters:
- DIN_W, 256, FIFO read-word width.
- DOUT_W, 32, pipe beat width; DIN_W must be an integer multiple of DOUT_W.
- BEATS, DIN_W/DOUT_W = 8, beats per FIFO word (derived, not overridable).
- CNT_W, 7, width of the FIFO read-data-count input.
- BLOCK_WORDS, 16, FIFO words per host block (16 words x 8 beats = 128 beats = 512 bytes); range 1 to 2^CNT_W-1.

Ports:
- clk, in, 1, FIFO read clock (same net as FIFO rd_clk).
- rst, in, 1, asynchronous, active-high reset.
- fifo_rd_en, out, 1, FIFO read enable.
- fifo_empty, in, 1, FIFO empty flag.
- fifo_valid, in, 1, FIFO dout valid; standard (non-FWFT) FIFO, asserted 1 cycle after rd_en.
- fifo_data, in, DIN_W, FIFO dout.
- fifo_rd_data_cnt, in, CNT_W, FIFO read-side occupancy.
- pipe_ready, out, 1, a full block is available and no block is in progress.
- pipe_rd, in, 1, host read strobe; consumes the current pipe_data beat.
- pipe_data, out, DOUT_W, current beat (registered).
- underrun, out, 1, sticky flag: pipe_rd arrived with no beat available.
- blocks_done, out, 16, count of completed blocks; wraps at 0xFFFF to 0.

Behaviour:
- Reset: all outputs and internal state 0 asynchronously. pipe_ready=0, fifo_rd_en=0, pipe_data=0, underrun=0, blocks_done=0, skid empty, FSM=IDLE.
- Storage is a 2-entry word skid (head and tail). head drives pipe_data = head[DOUT_W*(k+1)-1 : DOUT_W*k], where k is the beat index 0..7 (beat 0 = bits [31:0]).
- Prefetch:
  - fifo_rd_en=1 when fifo_empty=0 and (entries held + reads in flight) < 2.
  - At most one read is in flight.
  - fifo_valid writes fifo_data into head if head is empty, otherwise into tail.
  - fifo_valid with no free slot is impossible by construction; assert it in simulation.
- held_words = entries held + in-flight read.
- FSM:
  - IDLE -> ARMED when fifo_rd_data_cnt + held_words >= BLOCK_WORDS; the sum is computed at CNT_W+2 bits. pipe_ready=1 from the cycle after the condition is registered.
  - ARMED: pipe_ready stays 1. First pipe_rd -> BLOCK; pipe_ready=0 in the following cycle; that strobe consumes beat 0.
  - BLOCK: each pipe_rd with head valid advances k. When k=BEATS-1, head is released, tail moves to head and k=0, all in the same cycle.
  - Beat counter counts to BLOCK_WORDS*BEATS-1. The last beat consumed -> IDLE and blocks_done+1.
- Zero-bubble requirement: with one pipe_rd every cycle, the next word is already in tail before beat 7 of head is consumed. The FIFO read latency of 1 is well under BEATS=8.
- Underrun:
  - pipe_rd while head is empty (any state), or in IDLE with pipe_ready=0, sets underrun.
  - The beat is not consumed, k and the beat counter do not advance, and pipe_data holds.
  - Cleared only by rst.
- pipe_data after the final beat of a block keeps showing the head slice (the next block's beat 0 if prefetched).
- The occupancy comparison tolerates fifo_rd_data_cnt lag: it may under-report only, never over-report.
- Reset mid-block: everything returns to IDLE immediately. The partial block is dropped and held words are discarded; the FIFO shares rst and is flushed externally.
- Simultaneous fifo_valid and head release in one cycle: the new word lands in the slot freed after the tail->head shift; there is no loss.

Decomposition:
- Package adc_rd_pkg holds:
  - DOUT_W and BEATS constants;
  - the state encoding (IDLE=2'd0, ARMED=2'd1, BLOCK=2'd2);
  - the blocks_done width constant.
- Sub-module fifo_word_skid2 is the 2-entry DIN_W skid with push/pop/count. The FSM, beat slicing and flags stay in the top.

Test Plan:
- Preload 16 words (word n = {8{n,24'h0 pattern per lane}}), hold pipe_rd=0 -> pipe_ready=1 within 3 cycles of cnt=14 with 2 words held. fifo_rd_en never exceeds 2 words prefetched.
- Continuous pipe_rd for 128 cycles -> beats emerge in order word0 lanes 0..7, then word1, with no repeat or skip. pipe_ready=0 throughout. blocks_done=1 after the last beat.
- Only 15 words available -> pipe_ready stays 0. Adding a 16th word -> pipe_ready=1 within 3 cycles.
- pipe_rd pulsed with FIFO empty in IDLE -> underrun=1, pipe_data unchanged. A subsequent full block still streams correctly and underrun remains 1.
- rst asserted at beat 40 of a block -> the same cycle gives all outputs 0 and FSM=IDLE. After refill, the next block starts at beat 0 of a fresh word.
- Drive blocks_done to 0xFFFF via repeated blocks (or force) and complete one more block -> blocks_done=0.
